// File: rtl/sevseg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with a blanking gap at the start of each slot.
// Optional leading-zero suppression is enabled by defining SEVSEG_LZ_BLANK_EN.
module sevseg_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int SLOT_CYCLES    = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   dig_out,
    output logic                    frame_tick
);

    localparam int CNT_W = $clog2(SLOT_CYCLES);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0]      CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_INV   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_INV    = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] DIG_INV   = (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] shadow_val;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [4*NUM_DIGITS-1:0] act_val;
    logic [NUM_DIGITS-1:0]   act_dp;
    logic [NUM_DIGITS-1:0]   lz_mask;

    logic                    slot_end;
    logic                    frame_end;
    logic [4*NUM_DIGITS-1:0] next_val;
    logic [NUM_DIGITS-1:0]   next_dp;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    // A load on the boundary edge bypasses the shadow so the new slot already uses it.
    assign next_val = load ? value : shadow_val;
    assign next_dp  = load ? dp_in : shadow_dp;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'h0:    seg_decode = 7'h7E;
            4'h1:    seg_decode = 7'h30;
            4'h2:    seg_decode = 7'h6D;
            4'h3:    seg_decode = 7'h79;
            4'h4:    seg_decode = 7'h33;
            4'h5:    seg_decode = 7'h5B;
            4'h6:    seg_decode = 7'h5F;
            4'h7:    seg_decode = 7'h70;
            4'h8:    seg_decode = 7'h7F;
            4'h9:    seg_decode = 7'h7B;
            4'hA:    seg_decode = 7'h77;
            4'hB:    seg_decode = 7'h1F;
            4'hC:    seg_decode = 7'h4E;
            4'hD:    seg_decode = 7'h3D;
            4'hE:    seg_decode = 7'h4F;
            default: seg_decode = 7'h47;
        endcase
    endfunction

`ifdef SEVSEG_LZ_BLANK_EN
    logic [NUM_DIGITS-1:0] next_mask;

    // Digit i is blank when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        next_mask  = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_above   = zero_above & (next_val[4*i +: 4] == 4'h0);
            next_mask[i] = zero_above;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lz_mask <= ~NUM_DIGITS'(1);
        end else if (slot_end) begin
            lz_mask <= next_mask;
        end
    end
`else
    assign lz_mask = '0;
`endif

    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_sup;
    logic [NUM_DIGITS-1:0] cur_onehot;

    always_comb begin
        cur_nib    = 4'h0;
        cur_dp     = 1'b0;
        cur_sup    = 1'b0;
        cur_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib       = act_val[4*i +: 4];
                cur_dp        = act_dp[i];
                cur_sup       = lz_mask[i];
                cur_onehot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            act_val    <= '0;
            act_dp     <= '0;
            seg_out    <= SEG_INV;
            dp_out     <= DP_INV;
            dig_out    <= DIG_INV;
            frame_tick <= 1'b0;
        end else begin
            cnt <= slot_end ? '0 : cnt + CNT_W'(1);
            if (slot_end) begin
                idx     <= frame_end ? '0 : idx + IDX_W'(1);
                act_val <= next_val;
                act_dp  <= next_dp;
            end
            if (load) begin
                shadow_val <= value;
                shadow_dp  <= dp_in;
            end
            frame_tick <= frame_end;

            // Outputs follow the counter/index state of the previous cycle.
            if (cnt >= CNT_BLANK) begin
                seg_out <= (cur_sup ? 7'h00 : seg_decode(cur_nib)) ^ SEG_INV;
                dp_out  <= (cur_dp & ~cur_sup) ^ DP_INV;
                dig_out <= cur_onehot ^ DIG_INV;
            end else begin
                seg_out <= SEG_INV;
                dp_out  <= DP_INV;
                dig_out <= DIG_INV;
            end
        end
    end

endmodule

// File: tb/tb_sevseg_scan_driver.sv
// Bench for sevseg_scan_driver: table-driven frames plus hand-written mid-slot load and mid-frame reset.
// Expectations follow SEVSEG_LZ_BLANK_EN when it is defined for the build.
module tb_sevseg_scan_driver;

    localparam int ND    = 4;
    localparam int SLOT  = 8;
    localparam int BLANK = 2;
    localparam int NV    = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic        load;
    logic [3:0]  dp_in;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  dig_out;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;
    int slot_k = 0;
    logic [12:0] exp_q[$];

    typedef struct {
        logic [15:0]     value;
        logic [3:0]      dp;
        logic [3:0][6:0] seg;    // active-high pattern per digit, [3] = leftmost
        logic [3:0]      dp_on;
    } vec_t;

    vec_t vecs[NV];

    sevseg_scan_driver #(
        .NUM_DIGITS    (ND),
        .SLOT_CYCLES   (SLOT),
        .BLANK_CYCLES  (BLANK),
        .SEG_ACTIVE_LOW(1),
        .DIG_ACTIVE_LOW(1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .value     (value),
        .load      (load),
        .dp_in     (dp_in),
        .seg_out   (seg_out),
        .dp_out    (dp_out),
        .dig_out   (dig_out),
        .frame_tick(frame_tick)
    );

    // Clock and step
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [15:0] v, input logic [3:0] dp,
                                input logic [27:0] seg, input logic [3:0] dp_on);
        vec_t r;
        r.value = v;
        r.dp    = dp;
        r.seg   = seg;
        r.dp_on = dp_on;
        return r;
    endfunction

    // Scoreboard compare: {frame_tick, dp_out, dig_out, seg_out}
    task automatic check(input string name, input logic [12:0] exp);
        logic [12:0] act;
        act = {frame_tick, dp_out, dig_out, seg_out};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got ft=%0b dp=%0b dig=%h seg=%h, expected ft=%0b dp=%0b dig=%h seg=%h",
                     name, act[12], act[11], act[10:7], act[6:0], exp[12], exp[11], exp[10:7], exp[6:0]);
        end
    endtask

    // Drives one slot (or its first nsteps cycles); optional load before cycle load_at.
    task automatic run_slot(input string name, input logic [6:0] seg_on, input logic dp_on,
                            input int nsteps, input int load_at,
                            input logic [15:0] lv, input logic [3:0] ldp);
        int         idx;
        logic       lit;
        logic       ft;
        logic [3:0] oh;
        logic [6:0] es;
        logic [3:0] ed;
        logic       ep;
        idx = slot_k % ND;
        oh  = 4'b0001 << idx;
        for (int j = 1; j <= nsteps; j++) begin
            if (j == load_at) begin
                value = lv;
                dp_in = ldp;
                load  = 1'b1;
            end
            step();
            load = 1'b0;
            lit  = (j > BLANK);
            ft   = (j == SLOT) && (idx == ND - 1);
            es   = lit ? ~seg_on : 7'h7F;
            ed   = lit ? ~oh : 4'hF;
            ep   = lit ? ~dp_on : 1'b1;
            exp_q.push_back({ft, ep, ed, es});
            check($sformatf("%s d%0d c%0d", name, idx, j), exp_q.pop_front());
        end
        slot_k++;
    endtask

    initial begin
`ifdef SEVSEG_LZ_BLANK_EN
        vecs[0] = mk(16'h0000, 4'b0000, {7'h00, 7'h00, 7'h00, 7'h7E}, 4'b0000);
        vecs[5] = mk(16'h0003, 4'b0100, {7'h00, 7'h00, 7'h00, 7'h79}, 4'b0000);
        vecs[6] = mk(16'h0050, 4'b0000, {7'h00, 7'h00, 7'h5B, 7'h7E}, 4'b0000);
        vecs[7] = mk(16'h0000, 4'b1111, {7'h00, 7'h00, 7'h00, 7'h7E}, 4'b0001);
`else
        vecs[0] = mk(16'h0000, 4'b0000, {7'h7E, 7'h7E, 7'h7E, 7'h7E}, 4'b0000);
        vecs[5] = mk(16'h0003, 4'b0100, {7'h7E, 7'h7E, 7'h7E, 7'h79}, 4'b0100);
        vecs[6] = mk(16'h0050, 4'b0000, {7'h7E, 7'h7E, 7'h5B, 7'h7E}, 4'b0000);
        vecs[7] = mk(16'h0000, 4'b1111, {7'h7E, 7'h7E, 7'h7E, 7'h7E}, 4'b1111);
`endif
        vecs[1] = mk(16'h1234, 4'b0000, {7'h30, 7'h6D, 7'h79, 7'h33}, 4'b0000);
        vecs[2] = mk(16'h5678, 4'b1001, {7'h5B, 7'h5F, 7'h70, 7'h7F}, 4'b1001);
        vecs[3] = mk(16'h9ABC, 4'b0000, {7'h7B, 7'h77, 7'h1F, 7'h4E}, 4'b0000);
        vecs[4] = mk(16'hDEF0, 4'b0000, {7'h3D, 7'h4F, 7'h47, 7'h7E}, 4'b0000);

        // Reset held three cycles: everything inactive
        rst   = 1'b1;
        load  = 1'b0;
        value = 16'h0000;
        dp_in = 4'h0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("reset c%0d", i), {1'b0, 1'b1, 4'hF, 7'h7F});
        end
        rst    = 1'b0;
        slot_k = 0;

        // Frame f shows vecs[f]; vecs[f+1] is loaded mid-way through its last slot
        for (int f = 0; f < NV; f++) begin
            int nf;
            nf = (f < NV - 1) ? f + 1 : f;
            for (int d = 0; d < ND; d++) begin
                run_slot($sformatf("vec%0d", f), vecs[f].seg[d], vecs[f].dp_on[d], SLOT,
                         (d == ND - 1 && f < NV - 1) ? 5 : 0, vecs[nf].value, vecs[nf].dp);
            end
        end

        // Load ABCD in the lit part of digit 2; then a load coinciding with the frame boundary
        run_slot("midload", vecs[NV-1].seg[0], vecs[NV-1].dp_on[0], SLOT, 0, 16'h0, 4'h0);
        run_slot("midload", vecs[NV-1].seg[1], vecs[NV-1].dp_on[1], SLOT, 0, 16'h0, 4'h0);
        run_slot("midload", vecs[NV-1].seg[2], vecs[NV-1].dp_on[2], SLOT, 5, 16'hABCD, 4'h0);
        run_slot("midload", 7'h77, 1'b0, SLOT, 8, 16'h8888, 4'h0);
        for (int d = 0; d < ND; d++) begin
            run_slot("edgeload", 7'h7F, 1'b0, SLOT, 0, 16'h0, 4'h0);
        end

        // Reset in the lit part of digit 2, then a clean restart from digit 0 with cleared shadow
        run_slot("prerst", 7'h7F, 1'b0, SLOT, 0, 16'h0, 4'h0);
        run_slot("prerst", 7'h7F, 1'b0, SLOT, 0, 16'h0, 4'h0);
        run_slot("prerst", 7'h7F, 1'b0, 4, 0, 16'h0, 4'h0);
        rst = 1'b1;
        step();
        check("midrst c0", {1'b0, 1'b1, 4'hF, 7'h7F});
        step();
        check("midrst c1", {1'b0, 1'b1, 4'hF, 7'h7F});
        rst    = 1'b0;
        slot_k = 0;
        for (int d = 0; d < ND; d++) begin
            run_slot("postrst", vecs[0].seg[d], vecs[0].dp_on[d], SLOT, 0, 16'h0, 4'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sevseg_scan_driver.md
Name: sevseg_scan_driver

Overview:
- Time-multiplexed driver for an N-digit common-anode seven-segment display.
- Holds a packed hex word in a shadow register and decodes one nibble per scan slot to segment patterns.
- Drives the matching digit enable, with a blanking gap to suppress ghosting.
- Sits between the calculator result path and the board display pins, and replaces per-digit decoders.

Parameters:
- NUM_DIGITS, 4: number of digits scanned (1..16).
- SLOT_CYCLES, 50000: clk cycles per digit slot (must be >= 2).
- BLANK_CYCLES, 500: cycles at the start of each slot with all digits off (must be < SLOT_CYCLES).
- SEG_ACTIVE_LOW, 1: 1 inverts segment outputs (segment lit = 0).
- DIG_ACTIVE_LOW, 1: 1 inverts digit enables (digit on = 0).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- value  in  4*NUM_DIGITS  packed hex digits; digit 0 = bits [3:0] (rightmost)
- load  in  1  capture value into shadow register
- dp_in  in  NUM_DIGITS  decimal point request per digit, captured with value
- seg_out  out  7  segments {a,b,c,d,e,f,g}, bit6 = a
- dp_out  out  1  decimal point of the active digit
- dig_out  out  NUM_DIGITS  one-hot digit enables
- frame_tick  out  1  one-cycle pulse when the scan wraps from the last digit to digit 0

Behaviour:
- Reset (rst=1 at a clk edge): shadow value and dp cleared to 0, slot counter = 0, digit index = 0. All outputs are in the inactive level: seg_out all off (7'h7F if SEG_ACTIVE_LOW), dp_out off, dig_out all off, frame_tick = 0. Asserting reset mid-slot or mid-frame aborts the scan immediately; there is no partial-slot completion.
- Load: when load=1 at an edge, the shadow takes value and dp_in. The new data is visible from the next slot boundary. A load during the current slot does not alter that slot's outputs. If load and a slot boundary coincide, the new data is used for the new slot.
- Slot counter: runs 0..SLOT_CYCLES-1. At the terminal count it returns to 0 and the digit index increments. The index wraps from NUM_DIGITS-1 to 0, and frame_tick pulses on that wrap edge.
- Blanking: while slot counter < BLANK_CYCLES, dig_out is all off and seg_out is all off. Otherwise exactly one dig_out bit is on, at the index position.
- Decode: active-high pattern (before polarity) for nibble 0..F is 7E, 30, 6D, 79, 33, 5B, 5F, 70, 7F, 7B, 77, 1F, 4E, 3D, 4F, 47 (hex).
- Latency: all outputs are registered. Outputs reflect the counter/index state one clk after that state is reached. For example, the first lit cycle of a slot appears one cycle after the counter reaches BLANK_CYCLES.
- Digit index arithmetic: the index is $clog2(NUM_DIGITS) bits, minimum 1. NUM_DIGITS=1 gives a constant index of 0, and frame_tick fires every slot.
- Widths: slot counter is $clog2(SLOT_CYCLES) bits. No overflow is permitted past SLOT_CYCLES-1.

Optional Feature:
- Macro SEVSEG_LZ_BLANK_EN.
- Defined: leading-zero suppression. Any digit above the most significant nonzero nibble of the shadow is blanked: segments off and dp off, but the digit enable still toggles normally. Digit 0 is never suppressed, so a value of 0 shows a single "0". The suppression mask is computed from the shadow register and is registered.
- Undefined: all digits are always displayed, including leading zeros.

Test Plan:
- Reset: hold rst 3 cycles, then release with load=0 -> dig_out=4'hF, seg_out=7'h7F, and frame_tick=0 during reset; the first lit slot shows digit 0 as "0" (seg_out=7'h01) with dig_out=4'hE.
- Scan order (SLOT_CYCLES=8, BLANK_CYCLES=2): load value=16'h1234 -> the slot sequence lights dig_out E, D, B, 7 with seg_out ~33, ~79, ~6D, ~30. Each slot is 6 lit cycles preceded by 2 all-off cycles. frame_tick pulses once every 32 cycles.
- Mid-slot load: load 16'hABCD during the lit portion of digit 2 -> digit 2 keeps its old pattern until the slot ends; the next slot (digit 3) shows ~77 ("A").
- Reset mid-frame: assert rst during digit 2 -> the next cycle's outputs are inactive; after release the scan restarts at digit 0 with a fresh blank period; the shadow reads 0.
- Decimal point: dp_in=4'b0100 loaded with 16'h0003 -> dp_out is active only while dig_out selects digit 2.
- SEVSEG_LZ_BLANK_EN defined: value=16'h0050 -> digits 3 and 2 show all-off segments; digits 1 and 0 show "5" and "0". value=16'h0000 -> only digit 0 shows "0".
